// File: rtl/echo_pkg.sv
// Shared constants, FSM state encoding and sample arithmetic helpers for the echo delay line.
package echo_pkg;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 13;
  localparam int SEL_W  = 10;
  localparam int SEL_SH = 3;
  localparam int DLY_W  = SEL_W + SEL_SH;
  localparam logic [DATA_W-1:0] MID = DATA_W'(1 << (DATA_W-1));

  typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [DATA_W+1:0] wide_t;

  // Offset-binary <-> two's complement is an MSB flip in both directions.
  function automatic sample_t to_signed(input logic [DATA_W-1:0] v);
    return sample_t'({~v[DATA_W-1], v[DATA_W-2:0]});
  endfunction

  function automatic logic [DATA_W-1:0] to_offset(input sample_t v);
    return {~v[DATA_W-1], v[DATA_W-2:0]};
  endfunction

  // Fits in DATA_W bits iff the top three bits agree; otherwise clamp by sign.
  function automatic sample_t sat(input wide_t v);
    if (v[DATA_W+1:DATA_W-1] == 3'b000 || v[DATA_W+1:DATA_W-1] == 3'b111)
      return v[DATA_W-1:0];
    else if (v[DATA_W+1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/echo_delay_line_if.sv
// Sample-path handshake between the ADC front end, the echo stage and its status consumers.
interface echo_delay_line_if;
  import echo_pkg::*;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic [SEL_W-1:0]  delay_sel;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  modport master (output data_valid, data_in, delay_sel,
                  input  data_out, out_valid, busy, overrun);
  modport slave  (input  data_valid, data_in, delay_sel,
                  output data_out, out_valid, busy, overrun);
endinterface

// File: rtl/echo_ram.sv
// Simple dual-port sample history RAM with registered read; no reset so it maps onto block RAM.
module echo_ram #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/echo_delay_line.sv
// Echo stage: mixes each sample with the one D samples back at half gain, saturating.
// ECHO_FEEDBACK_EN: history stores the mixed output (recursive echo) instead of the dry input.
module echo_delay_line
  import echo_pkg::*;
(
  input  logic sysclk,
  input  logic reset_n,
  echo_delay_line_if.slave bus
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q, q, wdata, data_out_q;
  logic [DLY_W-1:0]  d_q;
  logic [ADDR_W-1:0] wr_ptr, fill, rd_addr;
  sample_t           y_q, xs, ds, y_sat;
  wide_t             y;
  logic              hist_ok, out_valid_q, overrun_q, we;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.data_valid) state_d = RD;
      RD:      state_d = CALC;
      CALC:    state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // History is only trusted once D samples have actually been written since reset.
  always_comb begin
    rd_addr = wr_ptr - d_q[ADDR_W-1:0];
    hist_ok = (d_q != '0) && (32'(d_q) <= 32'(fill));
    xs      = to_signed(x_q);
    ds      = hist_ok ? to_signed(q) : '0;
    y       = wide_t'(xs) + wide_t'(ds >>> 1);
    y_sat   = sat(y);
    we      = (state_q == WR);
  end

`ifdef ECHO_FEEDBACK_EN
  assign wdata = to_offset(y_q);
`else
  assign wdata = x_q;
`endif

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      d_q         <= '0;
      y_q         <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      data_out_q  <= MID;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= (state_q == CALC);
      if (state_q == IDLE && bus.data_valid) begin
        x_q <= bus.data_in;
        d_q <= {bus.delay_sel, {SEL_SH{1'b0}}};
      end
      if (state_q == CALC) begin
        y_q        <= y_sat;
        data_out_q <= to_offset(y_sat);
      end
      if (state_q == WR) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (fill != '1) fill <= fill + ADDR_W'(1);
      end
      if (bus.data_valid && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  echo_ram #(.DW(DATA_W), .AW(ADDR_W)) u_ram (
    .clk  (sysclk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_addr),
    .q    (q)
  );

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;
endmodule
